// File: rtl/uart_rx_param_if.sv
// Receive-side bundle: serial line and consumer valid/ready with per-frame status.
// Master drives the line and accepts frames; slave is the receiver.
interface uart_rx_param_if #(parameter int DATA_BITS = 8);
  logic                 rx;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;

  modport master (output rx, rx_ready,
                  input  rx_data, rx_valid, frame_err, parity_err, overrun, busy);
  modport slave  (input  rx, rx_ready,
                  output rx_data, rx_valid, frame_err, parity_err, overrun, busy);
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled 2-of-3 voting, optional parity,
// 1/2 stop bits, small frame FIFO on a valid/ready port.
module uart_rx_param #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_param_if.slave bus
);
  localparam int DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE);
  localparam int DW  = $clog2(DIV+1);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS+1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DATA_BITS + 2;
  localparam logic [SW-1:0] S_V0  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_V1  = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] S_DEC = SW'(OVERSAMPLE/2 + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, PUSH} state_e;

  state_e               state_q, state_d;
  logic                 meta_q, rxs_q, rxs_prev_q;
  logic [DW-1:0]        div_q;
  logic [SW-1:0]        smp_q;
  logic [1:0]           vote_q;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 ferr_q, ferr_d, perr_q, perr_d;
  logic                 start_det, tick, dec, bit_v, push;

  // Arming needs a 1 in the previous clk so a held-low line yields one frame only.
  assign start_det = (state_q == IDLE) && rxs_prev_q && !rxs_q;
  assign tick      = (div_q == DW'(DIV-1));
  assign dec       = tick && (smp_q == S_DEC);
  assign bit_v     = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs_q) | (vote_q[1] & rxs_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      div_q      <= '0;
      smp_q      <= '0;
      vote_q     <= '0;
    end else begin
      meta_q     <= bus.rx;
      rxs_q      <= meta_q;
      rxs_prev_q <= rxs_q;
      if (start_det || tick) div_q <= '0;
      else                   div_q <= div_q + 1'b1;
      if (start_det)      smp_q <= '0;
      else if (tick)      smp_q <= (smp_q == SW'(OVERSAMPLE-1)) ? '0 : smp_q + 1'b1;
      if (tick && smp_q == S_V0) vote_q[0] <= rxs_q;
      if (tick && smp_q == S_V1) vote_q[1] <= rxs_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: if (start_det) begin
        state_d = START;
        bcnt_d  = '0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
      end
      START: if (dec) state_d = bit_v ? IDLE : DATA;
      DATA: if (dec) begin
        sh_d   = {bit_v, sh_q[DATA_BITS-1:1]};
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BW'(DATA_BITS-1)) begin
          bcnt_d  = '0;
          state_d = (PARITY != 0) ? PAR : STOP;
        end
      end
      PAR: if (dec) begin
        // Even parity wants XOR of data+parity = 0, odd wants 1.
        perr_d  = (^{sh_q, bit_v}) ^ (PARITY == 1);
        state_d = STOP;
      end
      STOP: if (dec) begin
        if (!bit_v) ferr_d = 1'b1;
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BW'(STOP_BITS-1)) state_d = PUSH;
      end
      PUSH: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0]   cnt_q;
  logic          full, pop, wr, overrun_q;

  assign full = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop  = (cnt_q != '0) && bus.rx_ready;
  assign wr   = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr) begin
        mem_q[wp_q] <= {sh_q, ferr_q, perr_q};
        wp_q        <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q     <= cnt_q + {{PW{1'b0}}, wr} - {{PW{1'b0}}, pop};
      overrun_q <= push && !wr;
    end
  end

  assign {bus.rx_data, bus.frame_err, bus.parity_err} = mem_q[rp_q];
  assign bus.rx_valid = (cnt_q != '0);
  assign bus.overrun  = overrun_q;
  assign bus.busy     = (state_q != IDLE);
endmodule
